// File: rtl/wb_commit_pkg.sv
// Shared constants and types for the write-back commit stage.
// Default widths and the hard-wired zero register index live here so the
// interface, top level and scoreboard agree on them.
package wb_commit_pkg;

    localparam int WB_DW        = 32;  // result / RF write data width
    localparam int WB_AW        = 5;   // register index width
    localparam int REG_ZERO_IDX = 0;   // register that always reads as zero

    // Skid buffer occupancy: the only state this stage carries besides the
    // scoreboard and output register.
    typedef enum logic {
        SKID_EMPTY = 1'b0,
        SKID_FULL  = 1'b1
    } skid_state_t;

endpackage

// File: rtl/wb_commit_if.sv
// Bundle of ALU, load, decode-query and RF write-port signals around
// wb_commit. The slave modport is the commit stage itself; the master
// modport is its environment (ALU, LSU, decode and register file).
interface wb_commit_if
    import wb_commit_pkg::*;
#(
    parameter int DW = WB_DW,
    parameter int AW = WB_AW
) ();

    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_dst;
    logic [DW-1:0] alu_val;

    logic          ld_iss_valid;
    logic [AW-1:0] ld_iss_dst;
    logic          ld_rsp_valid;
    logic [AW-1:0] ld_rsp_dst;
    logic [DW-1:0] ld_rsp_val;

    logic [AW-1:0] rR1;
    logic [AW-1:0] rR2;
    logic          busy1;
    logic          busy2;
    logic          fwd_hit1;
    logic          fwd_hit2;
    logic [DW-1:0] fwd_val1;
    logic [DW-1:0] fwd_val2;

    logic          we;
    logic [AW-1:0] wR;
    logic [DW-1:0] wD;
    logic          sb_err;

    modport slave (
        input  alu_valid, alu_dst, alu_val,
        input  ld_iss_valid, ld_iss_dst, ld_rsp_valid, ld_rsp_dst, ld_rsp_val,
        input  rR1, rR2,
        output alu_ready, busy1, busy2, fwd_hit1, fwd_hit2, fwd_val1, fwd_val2,
        output we, wR, wD, sb_err
    );

    modport master (
        output alu_valid, alu_dst, alu_val,
        output ld_iss_valid, ld_iss_dst, ld_rsp_valid, ld_rsp_dst, ld_rsp_val,
        output rR1, rR2,
        input  alu_ready, busy1, busy2, fwd_hit1, fwd_hit2, fwd_val1, fwd_val2,
        input  we, wR, wD, sb_err
    );

endinterface

// File: rtl/wb_scoreboard.sv
// Load scoreboard: one pending bit per architectural register. Issue sets a
// bit, the written load response clears it (set wins on a same-cycle
// collision), two combinational query ports feed decode, and a sticky error
// flags responses to idle registers and ALU writes to pending ones.
module wb_scoreboard
    import wb_commit_pkg::*;
#(
    parameter int AW = WB_AW
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_set_en,
    input  logic [AW-1:0] i_set_idx,
    input  logic          i_clr_en,
    input  logic [AW-1:0] i_clr_idx,
    input  logic          i_chk_en,
    input  logic [AW-1:0] i_chk_idx,
    input  logic [AW-1:0] i_q1_idx,
    input  logic [AW-1:0] i_q2_idx,
    output logic          o_busy1,
    output logic          o_busy2,
    output logic          o_err
);

    localparam int NREG = 1 << AW;

    logic [NREG-1:0] r_pend;
    logic [NREG-1:0] w_set_mask;
    logic [NREG-1:0] w_clr_mask;
    logic [NREG-1:0] w_pend_nxt;
    logic            w_err_evt;
    logic            r_err;

    // Next pending vector and protocol-violation detect from the current bits.
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (i_set_en && (i_set_idx != AW'(REG_ZERO_IDX)))
            w_set_mask[i_set_idx] = 1'b1;
        if (i_clr_en)
            w_clr_mask[i_clr_idx] = 1'b1;
        w_pend_nxt = (r_pend & ~w_clr_mask) | w_set_mask;
        w_err_evt  = (i_clr_en && !r_pend[i_clr_idx]) ||
                     (i_chk_en &&  r_pend[i_chk_idx]);
    end

    // Pending bits and sticky error; reset forgets every in-flight load.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_pend <= '0;
            r_err  <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            r_err  <= r_err | w_err_evt;
        end
    end

    assign o_busy1 = r_pend[i_q1_idx];
    assign o_busy2 = r_pend[i_q2_idx];
    assign o_err   = r_err;

endmodule

// File: rtl/wb_commit.sv
// Write-back commit stage: merges load responses and ALU results into one
// registered RF write port (priority load > skid buffer > ALU), tracks
// outstanding loads in wb_scoreboard and answers decode hazard queries.
// Optional build macro WB_BYPASS_EN forwards the in-flight write to decode;
// without it decode sees the output-stage register as busy instead.
module wb_commit
    import wb_commit_pkg::*;
#(
    parameter int DW = WB_DW,
    parameter int AW = WB_AW
) (
    input  logic     cpu_clk,
    input  logic     cpu_rstn,
    wb_commit_if.slave bus
);

    skid_state_t   r_skid_state;
    skid_state_t   w_skid_state_nxt;
    logic [AW-1:0] r_skid_dst;
    logic [DW-1:0] r_skid_val;
    logic          w_skid_load;

    logic          w_alu_ready;
    logic          w_alu_acc;
    logic          w_sel_vld;
    logic [AW-1:0] w_sel_dst;
    logic [DW-1:0] w_sel_val;
    logic          w_sel_we;

    logic          r_we_p1;
    logic [AW-1:0] r_wr_p1;
    logic [DW-1:0] r_wd_p1;

    logic          w_sb_busy1;
    logic          w_sb_busy2;
    logic          w_sb_err;
    logic          w_out_hit1;
    logic          w_out_hit2;

    assign w_alu_ready = (r_skid_state == SKID_EMPTY);
    assign w_alu_acc   = bus.alu_valid && w_alu_ready;

    // Source select and skid buffer control: a load response always wins and
    // parks a simultaneously accepted ALU result in the skid buffer.
    always_comb begin
        w_sel_vld        = 1'b0;
        w_sel_dst        = bus.alu_dst;
        w_sel_val        = bus.alu_val;
        w_skid_load      = 1'b0;
        w_skid_state_nxt = r_skid_state;
        if (bus.ld_rsp_valid) begin
            w_sel_vld = 1'b1;
            w_sel_dst = bus.ld_rsp_dst;
            w_sel_val = bus.ld_rsp_val;
            if (w_alu_acc) begin
                w_skid_load      = 1'b1;
                w_skid_state_nxt = SKID_FULL;
            end
        end else if (r_skid_state == SKID_FULL) begin
            w_sel_vld        = 1'b1;
            w_sel_dst        = r_skid_dst;
            w_sel_val        = r_skid_val;
            w_skid_state_nxt = SKID_EMPTY;
        end else if (w_alu_acc) begin
            w_sel_vld = 1'b1;
        end
        w_sel_we = w_sel_vld && (w_sel_dst != AW'(REG_ZERO_IDX));
    end

    // Skid buffer occupancy.
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rstn)
            r_skid_state <= SKID_EMPTY;
        else
            r_skid_state <= w_skid_state_nxt;
    end

    // Skid buffer payload; only meaningful while occupied, so it is not reset.
    always_ff @(posedge cpu_clk) begin
        if (w_skid_load) begin
            r_skid_dst <= bus.alu_dst;
            r_skid_val <= bus.alu_val;
        end
    end

    // ---- output stage: registered RF write port ----
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rstn) begin
            r_we_p1 <= 1'b0;
            r_wr_p1 <= '0;
            r_wd_p1 <= '0;
        end else begin
            r_we_p1 <= w_sel_we;
            if (w_sel_we) begin
                r_wr_p1 <= w_sel_dst;
                r_wd_p1 <= w_sel_val;
            end
        end
    end

    wb_scoreboard #(.AW(AW)) u_sb (
        .i_clk     (cpu_clk),
        .i_rstn    (cpu_rstn),
        .i_set_en  (bus.ld_iss_valid),
        .i_set_idx (bus.ld_iss_dst),
        .i_clr_en  (bus.ld_rsp_valid),
        .i_clr_idx (bus.ld_rsp_dst),
        .i_chk_en  (w_alu_acc),
        .i_chk_idx (bus.alu_dst),
        .i_q1_idx  (bus.rR1),
        .i_q2_idx  (bus.rR2),
        .o_busy1   (w_sb_busy1),
        .o_busy2   (w_sb_busy2),
        .o_err     (w_sb_err)
    );

    // Output stage is writing a decode source register this cycle.
    assign w_out_hit1 = r_we_p1 && (r_wr_p1 == bus.rR1) && (bus.rR1 != AW'(REG_ZERO_IDX));
    assign w_out_hit2 = r_we_p1 && (r_wr_p1 == bus.rR2) && (bus.rR2 != AW'(REG_ZERO_IDX));

`ifdef WB_BYPASS_EN
    assign bus.fwd_hit1 = w_out_hit1;
    assign bus.fwd_hit2 = w_out_hit2;
    assign bus.fwd_val1 = w_out_hit1 ? r_wd_p1 : '0;
    assign bus.fwd_val2 = w_out_hit2 ? r_wd_p1 : '0;
    assign bus.busy1    = w_sb_busy1;
    assign bus.busy2    = w_sb_busy2;
`else
    // No forwarding path: the register being written is not yet readable.
    assign bus.fwd_hit1 = 1'b0;
    assign bus.fwd_hit2 = 1'b0;
    assign bus.fwd_val1 = '0;
    assign bus.fwd_val2 = '0;
    assign bus.busy1    = w_sb_busy1 | w_out_hit1;
    assign bus.busy2    = w_sb_busy2 | w_out_hit2;
`endif

    assign bus.alu_ready = w_alu_ready;
    assign bus.we        = r_we_p1;
    assign bus.wR        = r_wr_p1;
    assign bus.wD        = r_wd_p1;
    assign bus.sb_err    = w_sb_err;

endmodule

// File: tb/tb_wb_commit.sv
// Testbench for wb_commit: directed scenarios followed by randomized traffic
// checked against a transaction-level reference (ALU results as an ordered
// FIFO behind load responses, scoreboard as a boolean array).
module tb_wb_commit;
    import wb_commit_pkg::*;

    localparam int DW = WB_DW;
    localparam int AW = WB_AW;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    wb_commit_if #(.DW(DW), .AW(AW)) bus ();

    wb_commit #(.DW(DW), .AW(AW)) dut (
        .cpu_clk  (clk),
        .cpu_rstn (rstn),
        .bus      (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state
    bit                 m_pend [1<<AW];
    logic [AW+DW-1:0]   m_q [$];
    bit                 m_err;
    logic               m_we;
    logic [AW-1:0]      m_wr;
    logic [DW-1:0]      m_wd;

    function automatic bit m_busy(logic [AW-1:0] idx);
        return m_pend[idx] || (!BYP && m_we && m_wr == idx && idx != 0);
    endfunction

    function automatic bit m_hit(logic [AW-1:0] idx);
        return BYP && m_we && m_wr == idx && idx != 0;
    endfunction

    task automatic idle();
        bus.alu_valid    = 1'b0;
        bus.alu_dst      = '0;
        bus.alu_val      = '0;
        bus.ld_iss_valid = 1'b0;
        bus.ld_iss_dst   = '0;
        bus.ld_rsp_valid = 1'b0;
        bus.ld_rsp_dst   = '0;
        bus.ld_rsp_val   = '0;
    endtask

    // Advance the reference by one cycle from the current inputs, then clock.
    task automatic tick();
        bit               acc;
        bit               has_w;
        logic [AW+DW-1:0] w;
        acc   = bus.alu_valid && (m_q.size() == 0);
        has_w = 1'b0;
        w     = '0;
        if (!rstn) begin
            foreach (m_pend[i]) m_pend[i] = 1'b0;
            m_q.delete();
            m_err = 1'b0;
            m_we  = 1'b0;
            m_wr  = '0;
            m_wd  = '0;
        end else begin
            if (bus.ld_rsp_valid && !m_pend[bus.ld_rsp_dst]) m_err = 1'b1;
            if (acc && m_pend[bus.alu_dst]) m_err = 1'b1;
            if (acc) m_q.push_back({bus.alu_dst, bus.alu_val});
            if (bus.ld_rsp_valid) begin
                w = {bus.ld_rsp_dst, bus.ld_rsp_val};
                has_w = 1'b1;
            end else if (m_q.size() > 0) begin
                w = m_q.pop_front();
                has_w = 1'b1;
            end
            if (has_w && w[DW +: AW] != 0) begin
                m_we = 1'b1;
                m_wr = w[DW +: AW];
                m_wd = w[DW-1:0];
            end else begin
                m_we = 1'b0;
            end
            if (bus.ld_rsp_valid) m_pend[bus.ld_rsp_dst] = 1'b0;
            if (bus.ld_iss_valid && bus.ld_iss_dst != 0) m_pend[bus.ld_iss_dst] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        bus.rR1 = AW'($urandom_range(1, 31));
        bus.rR2 = AW'($urandom_range(1, 31));
        rstn = 1'b0;
        tick();
        tick();
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%0b exp=0", bus.we); end
        n_checks++; if (bus.wR !== '0) begin n_fail++; $display("FAIL reset_wR got=%0d exp=0", bus.wR); end
        n_checks++; if (bus.wD !== '0) begin n_fail++; $display("FAIL reset_wD got=%h exp=0", bus.wD); end
        n_checks++; if (bus.sb_err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%0b exp=0", bus.sb_err); end
        n_checks++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%0b exp=1", bus.alu_ready); end
        n_checks++; if (bus.busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy1 got=%0b exp=0", bus.busy1); end
        rstn = 1'b1;
    endtask

    task automatic test_alu_write();
        idle();
        bus.alu_valid = 1'b1; bus.alu_dst = AW'(5); bus.alu_val = DW'(32'h1234);
        bus.rR1 = AW'(5);
        #1;
        n_checks++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL alu_ready got=%0b exp=1", bus.alu_ready); end
        tick();
        idle();
        #1;
        n_checks++; if (bus.we !== 1'b1) begin n_fail++; $display("FAIL alu_we got=%0b exp=1", bus.we); end
        n_checks++; if (bus.wR !== AW'(5)) begin n_fail++; $display("FAIL alu_wR got=%0d exp=5", bus.wR); end
        n_checks++; if (bus.wD !== DW'(32'h1234)) begin n_fail++; $display("FAIL alu_wD got=%h exp=1234", bus.wD); end
        n_checks++; if (bus.fwd_hit1 !== BYP) begin n_fail++; $display("FAIL alu_fwd_hit got=%0b exp=%0b", bus.fwd_hit1, BYP); end
        n_checks++; if (bus.fwd_val1 !== (BYP ? DW'(32'h1234) : DW'(0))) begin n_fail++; $display("FAIL alu_fwd_val got=%h", bus.fwd_val1); end
        n_checks++; if (bus.busy1 !== !BYP) begin n_fail++; $display("FAIL alu_busy got=%0b exp=%0b", bus.busy1, !BYP); end
        tick();
    endtask

    task automatic test_load();
        idle();
        bus.ld_iss_valid = 1'b1; bus.ld_iss_dst = AW'(7);
        tick();
        idle();
        bus.rR1 = AW'(7);
        #1;
        n_checks++; if (bus.busy1 !== 1'b1) begin n_fail++; $display("FAIL ld_busy_issued got=%0b exp=1", bus.busy1); end
        tick();
        tick();
        n_checks++; if (bus.busy1 !== 1'b1) begin n_fail++; $display("FAIL ld_busy_wait got=%0b exp=1", bus.busy1); end
        bus.ld_rsp_valid = 1'b1; bus.ld_rsp_dst = AW'(7); bus.ld_rsp_val = DW'(32'hA5A5);
        tick();
        idle();
        #1;
        n_checks++; if (bus.we !== 1'b1 || bus.wR !== AW'(7) || bus.wD !== DW'(32'hA5A5)) begin
            n_fail++; $display("FAIL ld_write got=%0b/%0d/%h exp=1/7/a5a5", bus.we, bus.wR, bus.wD); end
        n_checks++; if (bus.busy1 !== !BYP) begin n_fail++; $display("FAIL ld_busy_out got=%0b exp=%0b", bus.busy1, !BYP); end
        tick();
        n_checks++; if (bus.busy1 !== 1'b0) begin n_fail++; $display("FAIL ld_busy_clear got=%0b exp=0", bus.busy1); end
    endtask

    task automatic test_collision();
        idle();
        bus.ld_iss_valid = 1'b1; bus.ld_iss_dst = AW'(7);
        tick();
        idle();
        bus.alu_valid = 1'b1; bus.alu_dst = AW'(3); bus.alu_val = DW'(32'h11);
        bus.ld_rsp_valid = 1'b1; bus.ld_rsp_dst = AW'(7); bus.ld_rsp_val = DW'(32'h22);
        #1;
        n_checks++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL col_ready0 got=%0b exp=1", bus.alu_ready); end
        tick();
        idle();
        #1;
        n_checks++; if (bus.we !== 1'b1 || bus.wR !== AW'(7) || bus.wD !== DW'(32'h22)) begin
            n_fail++; $display("FAIL col_first got=%0b/%0d/%h exp=1/7/22", bus.we, bus.wR, bus.wD); end
        n_checks++; if (bus.alu_ready !== 1'b0) begin n_fail++; $display("FAIL col_ready1 got=%0b exp=0", bus.alu_ready); end
        tick();
        n_checks++; if (bus.we !== 1'b1 || bus.wR !== AW'(3) || bus.wD !== DW'(32'h11)) begin
            n_fail++; $display("FAIL col_second got=%0b/%0d/%h exp=1/3/11", bus.we, bus.wR, bus.wD); end
        n_checks++; if (bus.alu_ready !== 1'b1) begin n_fail++; $display("FAIL col_ready2 got=%0b exp=1", bus.alu_ready); end
        tick();
    endtask

    task automatic test_dst_zero();
        idle();
        bus.alu_valid = 1'b1; bus.alu_dst = '0; bus.alu_val = DW'(32'hFFFF);
        tick();
        idle();
        bus.rR1 = '0;
        #1;
        n_checks++; if (bus.we !== 1'b0) begin n_fail++; $display("FAIL z_we got=%0b exp=0", bus.we); end
        n_checks++; if (bus.busy1 !== 1'b0) begin n_fail++; $display("FAIL z_busy got=%0b exp=0", bus.busy1); end
        n_checks++; if (bus.fwd_hit1 !== 1'b0) begin n_fail++; $display("FAIL z_hit got=%0b exp=0", bus.fwd_hit1); end
        n_checks++; if (bus.sb_err !== 1'b0) begin n_fail++; $display("FAIL z_err got=%0b exp=0", bus.sb_err); end
        tick();
    endtask

    task automatic test_reset_inflight();
        idle();
        bus.ld_iss_valid = 1'b1; bus.ld_iss_dst = AW'(9);
        tick();
        idle();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        bus.ld_rsp_valid = 1'b1; bus.ld_rsp_dst = AW'(9); bus.ld_rsp_val = DW'(32'h99);
        tick();
        idle();
        bus.rR1 = AW'(9);
        tick();
        n_checks++; if (bus.sb_err !== 1'b1) begin n_fail++; $display("FAIL rst_err got=%0b exp=1", bus.sb_err); end
        n_checks++; if (bus.busy1 !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%0b exp=0", bus.busy1); end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        n_checks++; if (bus.sb_err !== 1'b0) begin n_fail++; $display("FAIL rst_err_clr got=%0b exp=0", bus.sb_err); end
    endtask

    task automatic test_same_cycle();
        idle();
        bus.ld_iss_valid = 1'b1; bus.ld_iss_dst = AW'(4);
        tick();
        idle();
        bus.ld_iss_valid = 1'b1; bus.ld_iss_dst = AW'(4);
        bus.ld_rsp_valid = 1'b1; bus.ld_rsp_dst = AW'(4); bus.ld_rsp_val = DW'(32'h44);
        tick();
        idle();
        bus.rR1 = AW'(4);
        #1;
        n_checks++; if (bus.we !== 1'b1 || bus.wR !== AW'(4) || bus.wD !== DW'(32'h44)) begin
            n_fail++; $display("FAIL same_write got=%0b/%0d/%h exp=1/4/44", bus.we, bus.wR, bus.wD); end
        tick();
        n_checks++; if (bus.busy1 !== 1'b1) begin n_fail++; $display("FAIL same_pend got=%0b exp=1", bus.busy1); end
        n_checks++; if (bus.sb_err !== 1'b0) begin n_fail++; $display("FAIL same_err got=%0b exp=0", bus.sb_err); end
        bus.ld_rsp_valid = 1'b1; bus.ld_rsp_dst = AW'(4); bus.ld_rsp_val = DW'(32'h45);
        tick();
        idle();
        tick();
    endtask

    task automatic test_random();
        logic [AW-1:0] oq [$];
        logic [AW-1:0] d;
        for (int cyc = 0; cyc < 400; cyc++) begin
            idle();
            if ($urandom_range(0, 99) < 50) begin
                d = AW'($urandom_range(0, 31));
                for (int t = 0; t < 8 && m_pend[d]; t++) d = AW'($urandom_range(0, 31));
                if (m_pend[d]) d = '0;
                bus.alu_valid = 1'b1; bus.alu_dst = d; bus.alu_val = DW'($urandom);
            end
            if (oq.size() > 0 && $urandom_range(0, 99) < 40) begin
                bus.ld_rsp_valid = 1'b1; bus.ld_rsp_dst = oq.pop_front(); bus.ld_rsp_val = DW'($urandom);
            end
            if ($urandom_range(0, 99) < 30) begin
                d = AW'($urandom_range(1, 31));
                if (!m_pend[d]) begin
                    bus.ld_iss_valid = 1'b1; bus.ld_iss_dst = d; oq.push_back(d);
                end
            end
            bus.rR1 = AW'($urandom_range(0, 31));
            bus.rR2 = (cyc % 3 == 0) ? m_wr : AW'($urandom_range(0, 31));
            #1;
            n_checks++; if (bus.alu_ready !== (m_q.size() == 0)) begin n_fail++; $display("FAIL rnd_ready c=%0d got=%0b exp=%0b", cyc, bus.alu_ready, m_q.size() == 0); end
            n_checks++; if (bus.busy1 !== m_busy(bus.rR1)) begin n_fail++; $display("FAIL rnd_busy1 c=%0d got=%0b exp=%0b", cyc, bus.busy1, m_busy(bus.rR1)); end
            n_checks++; if (bus.busy2 !== m_busy(bus.rR2)) begin n_fail++; $display("FAIL rnd_busy2 c=%0d got=%0b exp=%0b", cyc, bus.busy2, m_busy(bus.rR2)); end
            n_checks++; if (bus.fwd_hit2 !== m_hit(bus.rR2)) begin n_fail++; $display("FAIL rnd_hit2 c=%0d got=%0b exp=%0b", cyc, bus.fwd_hit2, m_hit(bus.rR2)); end
            n_checks++; if (bus.fwd_val2 !== (m_hit(bus.rR2) ? m_wd : DW'(0))) begin n_fail++; $display("FAIL rnd_fval2 c=%0d got=%h", cyc, bus.fwd_val2); end
            tick();
            n_checks++; if (bus.we !== m_we) begin n_fail++; $display("FAIL rnd_we c=%0d got=%0b exp=%0b", cyc, bus.we, m_we); end
            if (m_we) begin
                n_checks++; if (bus.wR !== m_wr || bus.wD !== m_wd) begin
                    n_fail++; $display("FAIL rnd_wdata c=%0d got=%0d/%h exp=%0d/%h", cyc, bus.wR, bus.wD, m_wr, m_wd); end
            end
            n_checks++; if (bus.sb_err !== m_err) begin n_fail++; $display("FAIL rnd_err c=%0d got=%0b exp=%0b", cyc, bus.sb_err, m_err); end
        end
        while (oq.size() > 0) begin
            idle();
            bus.ld_rsp_valid = 1'b1; bus.ld_rsp_dst = oq.pop_front(); bus.ld_rsp_val = DW'($urandom);
            tick();
            n_checks++; if (bus.we !== m_we || bus.wR !== m_wr) begin n_fail++; $display("FAIL drain_write got=%0b/%0d exp=%0b/%0d", bus.we, bus.wR, m_we, m_wr); end
        end
        idle();
        tick();
        tick();
    endtask

    initial begin
        idle();
        bus.rR1 = '0;
        bus.rR2 = '0;
        test_reset();
        test_alu_write();
        test_load();
        test_collision();
        test_dst_zero();
        test_reset_inflight();
        test_same_cycle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
